// File: rtl/multicycle_control_unit.sv
// Multicycle ARM-style control FSM: sequences fetch/decode/execute and drives datapath controls.
// Latency: LDR 5, STR 4, DP 4, B 3, illegal 2 cycles; no backpressure, advances every clock.
module multicycle_control_unit #(
    parameter int         ALU_CTRL_W = 3,
    parameter logic [3:0] PC_REG     = 4'd15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            cond,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            rd,
    input  logic [3:0]            alu_flags,
    output logic                  pc_we,
    output logic                  adr_src,
    output logic                  mem_we,
    output logic                  ir_we,
    output logic                  reg_we,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            result_src,
    output logic [1:0]            imm_src,
    output logic [1:0]            reg_src,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [3:0]            flags,
    output logic [3:0]            state
);

    generate
        if (ALU_CTRL_W < 3) begin : g_bad_width
            $error("multicycle_control_unit: ALU_CTRL_W must be at least 3");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_ORR = 3'd3;
    localparam logic [2:0] ALU_EOR = 3'd4;

    state_t state_r;
    state_t state_nxt;

    logic       is_imm;
    logic [3:0] cmd;
    logic       s_l;
    logic       rd_is_pc;

    assign is_imm   = funct[5];
    assign cmd      = funct[4:1];
    assign s_l      = funct[0];
    assign rd_is_pc = (rd == PC_REG);

    // Data-processing command decode
    logic [2:0] dec_alu;
    logic       dec_known;
    logic       dec_wb;
    logic       dec_logic;
    logic       dec_cmp;

    always_comb begin
        dec_alu   = ALU_ADD;
        dec_known = 1'b1;
        dec_wb    = 1'b1;
        dec_logic = 1'b0;
        dec_cmp   = 1'b0;
        case (cmd)
            4'b0100: dec_alu = ALU_ADD;
            4'b0010: dec_alu = ALU_SUB;
            4'b0000: begin
                dec_alu   = ALU_AND;
                dec_logic = 1'b1;
            end
            4'b1100: begin
                dec_alu   = ALU_ORR;
                dec_logic = 1'b1;
            end
            4'b0001: begin
                dec_alu   = ALU_EOR;
                dec_logic = 1'b1;
            end
            4'b1010: begin
                dec_alu = ALU_SUB;
                dec_wb  = 1'b0;
                dec_cmp = 1'b1;
            end
            default: begin
                dec_alu   = ALU_ADD;
                dec_known = 1'b0;
                dec_wb    = 1'b0;
            end
        endcase
    end

    // Condition check against the architectural (registered) flags
    logic flag_n;
    logic flag_z;
    logic flag_c;
    logic flag_v;
    logic cond_ex;

    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~(flag_c & ~flag_z);
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = ~(~flag_z & (flag_n == flag_v));
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    logic in_exec;
    logic flag_upd;

    assign in_exec  = (state_r == S_EXECR) || (state_r == S_EXECI);
    assign flag_upd = in_exec & dec_known & (s_l | dec_cmp) & cond_ex;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_FETCH;
            flags   <= 4'b0000;
        end else begin
            state_r <= state_nxt;
            if (flag_upd) begin
                // Logical ops only produce N and Z; C and V keep their old values
                if (dec_logic) flags <= {alu_flags[3:2], flags[1:0]};
                else           flags <= alu_flags;
            end
        end
    end

    assign state = state_r;

    always_comb begin
        state_nxt = S_FETCH;
        case (state_r)
            S_FETCH:  state_nxt = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b00:   state_nxt = is_imm ? S_EXECI : S_EXECR;
                    2'b01:   state_nxt = S_MEMADR;
                    2'b10:   state_nxt = S_BRANCH;
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEMADR: state_nxt = s_l ? S_MEMRD : S_MEMWR;
            S_MEMRD:  state_nxt = S_MEMWB;
            S_EXECR:  state_nxt = S_ALUWB;
            S_EXECI:  state_nxt = S_ALUWB;
            default:  state_nxt = S_FETCH;
        endcase
    end

    assign imm_src = op;
    assign reg_src = {(op == 2'b01) & ~s_l, (op == 2'b10)};

    always_comb begin
        pc_we      = 1'b0;
        adr_src    = 1'b0;
        mem_we     = 1'b0;
        ir_we      = 1'b0;
        reg_we     = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_ctrl   = '0;
        case (state_r)
            S_FETCH: begin
                ir_we      = 1'b1;
                pc_we      = 1'b1;
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_MEMADR: begin
                alu_src_b = 2'b01;
            end
            S_MEMRD: begin
                adr_src = 1'b1;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_we     = cond_ex;
                pc_we      = cond_ex & rd_is_pc;
            end
            S_MEMWR: begin
                adr_src = 1'b1;
                mem_we  = cond_ex;
            end
            S_EXECR: begin
                alu_ctrl = ALU_CTRL_W'(dec_alu);
            end
            S_EXECI: begin
                alu_src_b = 2'b01;
                alu_ctrl  = ALU_CTRL_W'(dec_alu);
            end
            S_ALUWB: begin
                reg_we = cond_ex & dec_wb;
                pc_we  = cond_ex & dec_wb & rd_is_pc;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_we      = cond_ex;
            end
            default: ;
        endcase
        // Reset overrides every architectural write, whatever state is held
        if (rst) begin
            pc_we  = 1'b0;
            ir_we  = 1'b0;
            reg_we = 1'b0;
            mem_we = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: walks each instruction class and checks
// state sequence, control outputs and flag updates against hand-computed values.
module tb_multicycle_control_unit;

    logic       clk;
    logic       rst;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       pc_we;
    logic       adr_src;
    logic       mem_we;
    logic       ir_we;
    logic       reg_we;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic [1:0] reg_src;
    logic [2:0] alu_ctrl;
    logic [3:0] flags;
    logic [3:0] state;

    int n_total = 0;
    int n_pass  = 0;

    multicycle_control_unit #(.ALU_CTRL_W(3), .PC_REG(4'd15)) dut (
        .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .pc_we(pc_we), .adr_src(adr_src), .mem_we(mem_we),
        .ir_we(ir_we), .reg_we(reg_we), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .imm_src(imm_src), .reg_src(reg_src),
        .alu_ctrl(alu_ctrl), .flags(flags), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                             input logic [3:0] r, input logic [3:0] af);
        cond = c; op = o; funct = f; rd = r; alu_flags = af;
        #1;
    endtask

    logic [3:0] wes;
    assign wes = {pc_we, ir_we, reg_we, mem_we};

    initial begin
        rst = 1'b1;
        set_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0000);
        step();
        check("rst_wes", wes, 4'b0000);
        check("rst_state", state, 0);
        check("rst_flags", flags, 4'b0000);
        rst = 1'b0;
        #1;
        check("first_fetch_wes", wes, 4'b1100);

        // BEQ with Z=0: not taken
        set_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
        check("beq0_fetch_srcs", {alu_src_a, alu_src_b, result_src}, 6'b011010);
        step(); check("beq0_s1", state, 1);
        step(); check("beq0_s9", state, 9);
        check("beq0_pcwe", pc_we, 0);
        check("beq0_regsrc_imm", {reg_src, imm_src}, 4'b0110);
        step(); check("beq0_s0", state, 0);

        // ADDS r1, register form
        set_instr(4'b1110, 2'b00, 6'b001001, 4'd1, 4'b0110);
        step(); check("adds_s1", state, 1);
        check("adds_dec_wes", wes, 4'b0000);
        step(); check("adds_s6", state, 6);
        check("adds_ctrl", alu_ctrl, 0);
        check("adds_srcb", alu_src_b, 0);
        check("adds_flags_pre", flags, 4'b0000);
        step(); check("adds_s8", state, 8);
        check("adds_flags", flags, 4'b0110);
        check("adds_wes", wes, 4'b0010);
        check("adds_ressrc", result_src, 0);
        step(); check("adds_s0", state, 0);

        // CMP: flags update, no writeback
        set_instr(4'b1110, 2'b00, 6'b010100, 4'd0, 4'b1000);
        step(); step();
        check("cmp_ctrl", alu_ctrl, 1);
        step(); check("cmp_s8", state, 8);
        check("cmp_flags", flags, 4'b1000);
        check("cmp_regwe", reg_we, 0);
        step();

        // ADDS to preload 0011, then ANDS immediate keeps C,V
        set_instr(4'b1110, 2'b00, 6'b001001, 4'd2, 4'b0011);
        step(); step(); step();
        check("pre_flags", flags, 4'b0011);
        step();
        set_instr(4'b1110, 2'b00, 6'b100001, 4'd3, 4'b0111);
        step(); step(); check("ands_s7", state, 7);
        check("ands_ctrl_srcb", {alu_ctrl, alu_src_b}, 5'b01001);
        step(); check("ands_flags", flags, 4'b0111);
        step();

        // BEQ with Z=1: taken
        set_instr(4'b0000, 2'b10, 6'b100000, 4'd0, 4'b0000);
        step(); step(); check("beq1_s9", state, 9);
        check("beq1_pcwe", pc_we, 1);
        step();

        // ADDS NE with Z=1: condition fails, no write, flags held
        set_instr(4'b0001, 2'b00, 6'b001001, 4'd4, 4'b0000);
        step(); step(); step();
        check("ne_wes", wes, 4'b0000);
        check("ne_flags", flags, 4'b0111);
        step();

        // Unknown cmd 0110 with S: acts as ADD, no writeback, no flag update
        set_instr(4'b1110, 2'b00, 6'b001101, 4'd5, 4'b1111);
        step(); step(); check("unk_ctrl", alu_ctrl, 0);
        step(); check("unk_regwe", reg_we, 0);
        check("unk_flags", flags, 4'b0111);
        step();

        // LDR r15
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd15, 4'b0000);
        step(); step(); check("ldr_s2", state, 2);
        check("ldr_memadr", {alu_src_a, alu_src_b, alu_ctrl}, 7'b0001000);
        step(); check("ldr_s3", state, 3);
        check("ldr_adrsrc", adr_src, 1);
        step(); check("ldr_s4", state, 4);
        check("ldr_wes", wes, 4'b1010);
        check("ldr_ressrc", result_src, 1);
        step(); check("ldr_s0", state, 0);

        // STR AL writes memory
        set_instr(4'b1110, 2'b01, 6'b100000, 4'd6, 4'b0000);
        step(); step(); step(); check("str_s5", state, 5);
        check("str_wes", wes, 4'b0001);
        check("str_adr_regsrc", {adr_src, reg_src}, 3'b110);
        step(); check("str_s0", state, 0);

        // STR never-condition suppresses mem_we
        set_instr(4'b1111, 2'b01, 6'b100000, 4'd6, 4'b0000);
        step(); step(); step(); check("strnv_s5", state, 5);
        check("strnv_memwe", mem_we, 0);
        step();

        // Illegal opcode
        set_instr(4'b1110, 2'b11, 6'b000000, 4'd0, 4'b0000);
        step(); check("ill_s1", state, 1);
        check("ill_wes", wes, 4'b0000);
        step(); check("ill_s0", state, 0);

        // Reset mid-LDR in MEMRD
        set_instr(4'b1110, 2'b01, 6'b011001, 4'd7, 4'b0000);
        step(); step(); step(); check("rstm_s3", state, 3);
        rst = 1'b1;
        #1;
        check("rstm_wes_hold", wes, 4'b0000);
        step(); check("rstm_state", state, 0);
        check("rstm_flags", flags, 4'b0000);
        check("rstm_wes", wes, 4'b0000);
        rst = 1'b0;
        #1;
        check("rstm_fetch_wes", wes, 4'b1100);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter ALU_CTRL_W, default 3, width of alu_ctrl; values below 3 SHALL be rejected at elaboration.
REQ-002 Parameter PC_REG, default 4'd15, register number treated as the PC.
REQ-003 clk  in  1  single clock; all state changes SHALL occur on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 cond  in  4  instruction condition field.
REQ-006 op  in  2  opcode: 00 DP, 01 MEM, 10 B, 11 illegal.
REQ-007 funct  in  6  [5]=I (immediate), [4:1]=cmd, [0]=S (DP) or L (MEM).
REQ-008 rd  in  4  destination register number.
REQ-009 alu_flags  in  4  live ALU {N,Z,C,V}.
REQ-010 Outputs SHALL be: pc_we 1, adr_src 1, mem_we 1, ir_we 1, reg_we 1, alu_src_a 2, alu_src_b 2, result_src 2, imm_src 2, reg_src 2, alu_ctrl ALU_CTRL_W, flags 4 (registered NZCV), state 4 (debug).

Function
REQ-011 The FSM SHALL use encodings FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9, driven on state.
REQ-012 Transitions: FETCH->DECODE; DECODE->MEMADR (op 01), EXECI (op 00, I=1), EXECR (op 00, I=0), BRANCH (op 10), FETCH (op 11); MEMADR->MEMRD (L=1) or MEMWR (L=0); MEMRD->MEMWB; EXECR/EXECI->ALUWB; MEMWB, MEMWR, ALUWB, BRANCH->FETCH.
REQ-013 Instruction latency SHALL be: LDR 5 cycles, STR 4, DP 4, B 3, illegal 2.
REQ-014 FETCH SHALL drive: ir_we=1, pc_we=1, adr_src=0, alu_src_a=01 (PC), alu_src_b=10 (const 4), result_src=10 (ALU direct), alu_ctrl=ADD.
REQ-015 DECODE SHALL drive: alu_src_a=01, alu_src_b=10, result_src=10, alu_ctrl=ADD; no write enables.
REQ-016 MEMADR SHALL drive alu_src_a=00, alu_src_b=01, alu_ctrl=ADD. MEMRD SHALL drive adr_src=1. MEMWR SHALL drive adr_src=1 and mem_we=cond_ex.
REQ-017 MEMWB SHALL drive result_src=01 and reg_we=cond_ex; it SHALL also assert pc_we=cond_ex when rd==PC_REG.
REQ-018 EXECR SHALL drive alu_src_a=00, alu_src_b=00. EXECI SHALL drive alu_src_a=00, alu_src_b=01. Both SHALL drive alu_ctrl from cmd.
REQ-019 ALUWB SHALL drive result_src=00 and reg_we=cond_ex&~CMP; it SHALL also assert pc_we=cond_ex&~CMP when rd==PC_REG.
REQ-020 BRANCH SHALL drive alu_src_a=00, alu_src_b=01, result_src=10, alu_ctrl=ADD, pc_we=cond_ex.
REQ-021 cmd decode: 0100 ADD->0, 0010 SUB->1, 0000 AND->2, 1100 ORR->3, 0001 EOR->4, 1010 CMP->1 (no writeback, S implied); any other cmd SHALL be treated as ADD with no writeback and no flag update.
REQ-022 In all states other than EXECR/EXECI, alu_ctrl SHALL be 0. imm_src SHALL equal op. reg_src SHALL be {op==01&L==0, op==10}.
REQ-023 The flags register SHALL load on the clock edge leaving EXECR/EXECI when (S or CMP) and cond_ex: NZCV for ADD/SUB/CMP; NZ only for AND/ORR/EOR, with C and V held.
REQ-024 cond_ex SHALL be evaluated from registered flags: EQ Z, NE ~Z, CS C, CC ~C, MI N, PL ~N, VS V, VC ~V, HI C&~Z, LS ~(C&~Z), GE N==V, LT N!=V, GT ~Z&(N==V), LE ~(~Z&(N==V)), 1110 AL 1, 1111 0.
REQ-025 A failed condition SHALL suppress every write enable except the FETCH-state ir_we and pc_we; state sequencing SHALL be unchanged.
REQ-026 All outputs except flags and state SHALL be combinational functions of state, the instruction fields, and flags.

Reset
REQ-027 When rst=1 at a clock edge, state SHALL become FETCH and flags SHALL become 0000, regardless of the current state, including mid-instruction.
REQ-028 While rst=1, pc_we, ir_we, reg_we and mem_we SHALL be 0.
REQ-029 The first FETCH after rst deasserts SHALL assert ir_we=1 and pc_we=1.

Verification
REQ-030 ADDS r1 with op=00, I=0, cmd=0100, S=1, cond=1110, alu_flags=0110 -> state sequence 0,1,6,8,0; reg_we=1 in state 8; flags=0110 after leaving state 6.
REQ-031 LDR with rd=15, cond=1110 -> state sequence 0,1,2,3,4; reg_we=1 and pc_we=1 in state 4; adr_src=1 in state 3.
REQ-032 BEQ with flags Z=0 -> sequence 0,1,9,0 with pc_we=0 in state 9; repeat with Z=1 -> pc_we=1 in state 9.
REQ-033 CMP with cond=1110, alu_flags=1000 -> flags=1000; reg_we=0 in ALUWB. ANDS with alu_flags=0111 and prior flags 0011 -> flags=0111.
REQ-034 rst asserted while state=3 (MEMRD) -> state=0 and flags=0000 on the next edge; mem_we=0 and reg_we=0 throughout.
REQ-035 op=11 -> state sequence 0,1,0 with no write enable asserted in DECODE; cond=1111 on STR -> mem_we=0 in MEMWR.
